frida_seq_ctrl: RTL and testbench

FRIDA_SEQ_CTRL -- requirements
Module: frida_seq_ctrl

---
 rtl/frida_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_frida_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frida_seq_ctrl.sv
// SAR conversion sequencer: steps INIT/SAMP/CMP/LOGIC across the enabled ADCs
// round-robin and hands each result out over a valid/ready port with overrun tracking.
module frida_seq_ctrl #(
  parameter int NBITS = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic [15:0]      chan_mask,
  input  logic [CNT_W-1:0] t_init,
  input  logic [CNT_W-1:0] t_samp,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_cmp,
  output logic             seq_logic,
  output logic [3:0]       adc_sel,
  output logic             busy,
  output logic [NBITS-1:0] res_data,
  output logic [3:0]       res_chan,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SAMP, S_CMP, S_LOGIC, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [NBITS-1:0] r_shift;
  logic             r_stop_pend;
  logic [3:0]       r_adc_sel;
  logic             r_busy;
  logic             r_seq_init, r_seq_samp, r_seq_cmp, r_seq_logic;
  logic [NBITS-1:0] r_res_data;
  logic [3:0]       r_res_chan;
  logic             r_res_valid;
  logic             r_overrun;

  logic w_start_ok, w_continue, w_load;

  // Next enabled ADC searching upward from cur (inclusive or strictly after), wrapping 15->0.
  function automatic logic [3:0] f_next_sel(input logic [15:0] mask, input logic [3:0] cur,
                                            input logic incl);
    logic [3:0] sel;
    logic [3:0] c;
    logic       found;
    sel   = cur;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      c = cur + 4'(k) + {3'b000, ~incl};
      if (!found && mask[c]) begin
        sel   = c;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_start_ok = start && (chan_mask != 16'h0000);
  assign w_continue = continuous && !(r_stop_pend || stop) && (chan_mask != 16'h0000);
  assign w_load     = !r_res_valid || res_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_INIT;
      S_INIT:  if (r_cnt == '0) w_state_nxt = S_SAMP;
      S_SAMP:  if (r_cnt == '0) w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_LOGIC;
      S_LOGIC: w_state_nxt = (r_idx == '0) ? S_DONE : S_CMP;
      S_DONE:  w_state_nxt = w_continue ? S_INIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_stop_pend <= 1'b0;
      r_adc_sel   <= 4'd0;
      r_busy      <= 1'b0;
      r_seq_init  <= 1'b0;
      r_seq_samp  <= 1'b0;
      r_seq_cmp   <= 1'b0;
      r_seq_logic <= 1'b0;
      r_res_data  <= '0;
      r_res_chan  <= 4'd0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_seq_init  <= (w_state_nxt == S_INIT);
      r_seq_samp  <= (w_state_nxt == S_SAMP);
      r_seq_cmp   <= (w_state_nxt == S_CMP);
      r_seq_logic <= (w_state_nxt == S_LOGIC);

      if (r_state == S_IDLE) r_stop_pend <= 1'b0;
      else if (stop)         r_stop_pend <= 1'b1;

      // Phase durations are captured as each phase is entered.
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_adc_sel <= f_next_sel(chan_mask, r_adc_sel, 1'b1);
            r_cnt     <= t_init;
          end
        end
        S_INIT: begin
          if (r_cnt == '0) r_cnt <= t_samp;
          else             r_cnt <= r_cnt - 1'b1;
        end
        S_SAMP: begin
          if (r_cnt == '0) r_idx <= IDX_W'(NBITS - 1);
          else             r_cnt <= r_cnt - 1'b1;
        end
        S_LOGIC: begin
          r_shift[r_idx] <= comp_out;
          if (r_idx != '0) r_idx <= r_idx - 1'b1;
        end
        S_DONE: begin
          r_adc_sel <= f_next_sel(chan_mask, r_adc_sel, 1'b0);
          if (w_continue) r_cnt <= t_init;
        end
        default: ;
      endcase

      // A new result may only replace an unread one when it is being consumed now.
      if (r_state == S_DONE && w_load) begin
        r_res_valid <= 1'b1;
        r_res_data  <= r_shift;
        r_res_chan  <= r_adc_sel;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (r_state == S_DONE && !w_load) r_overrun <= 1'b1;
      else if (clr_overrun)             r_overrun <= 1'b0;
    end
  end

  assign seq_init  = r_seq_init;
  assign seq_samp  = r_seq_samp;
  assign seq_cmp   = r_seq_cmp;
  assign seq_logic = r_seq_logic;
  assign adc_sel   = r_adc_sel;
  assign busy      = r_busy;
  assign res_data  = r_res_data;
  assign res_chan  = r_res_chan;
  assign res_valid = r_res_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_frida_seq_ctrl.sv
// Scoreboard bench for frida_seq_ctrl: random conversions against a round-robin
// channel model, plus directed single-shot, wrap, backpressure, boundary and reset cases.
module tb_frida_seq_ctrl;
  localparam int NBITS = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, continuous, stop, comp_out, res_ready, clr_overrun;
  logic [15:0]      chan_mask;
  logic [CNT_W-1:0] t_init, t_samp;
  logic             seq_init, seq_samp, seq_cmp, seq_logic, busy, res_valid, overrun;
  logic [3:0]       adc_sel, res_chan;
  logic [NBITS-1:0] res_data;

  frida_seq_ctrl #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .stop(stop),
    .chan_mask(chan_mask), .t_init(t_init), .t_samp(t_samp), .comp_out(comp_out),
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp), .seq_logic(seq_logic),
    .adc_sel(adc_sel), .busy(busy), .res_data(res_data), .res_chan(res_chan),
    .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [NBITS-1:0] data; logic [3:0] chan; } res_t;
  res_t             sb[$];
  logic [NBITS-1:0] wq[$];
  int               checks = 0, errors = 0;
  int               bitidx = NBITS - 1;
  logic [3:0]       msel = 4'd0;
  int               n_busy, n_init, n_samp, n_cmp, n_logic, n_multi, n_init_rise;
  logic             prev_init = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference channel model: walk the mask by offset, modulo 16.
  function automatic logic [3:0] first_at(input logic [15:0] m, input logic [3:0] s);
    int si = int'(s);
    for (int k = 0; k < 16; k++) if (m[(si + k) % 16]) return 4'((si + k) % 16);
    return s;
  endfunction

  function automatic logic [3:0] next_after(input logic [15:0] m, input logic [3:0] s);
    int si = int'(s);
    for (int k = 1; k <= 16; k++) if (m[(si + k) % 16]) return 4'((si + k) % 16);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor, activity counters and comparator driver, all away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data %0d chan %0d expected none", res_data, res_chan);
        end else begin
          chk("res_data", 32'(res_data), 32'(sb[0].data));
          chk("res_chan", 32'(res_chan), 32'(sb[0].chan));
          if (res_ready) void'(sb.pop_front());
        end
      end
      if (busy)      n_busy++;
      if (seq_init)  n_init++;
      if (seq_samp)  n_samp++;
      if (seq_cmp)   n_cmp++;
      if (seq_logic) n_logic++;
      if (32'(seq_init) + 32'(seq_samp) + 32'(seq_cmp) + 32'(seq_logic) > 1) n_multi++;
      if (seq_init && !prev_init) n_init_rise++;
      prev_init = seq_init;
      if (seq_logic) begin
        comp_out = (wq.size() != 0) ? wq[0][bitidx] : 1'($urandom);
        if (bitidx == 0) begin
          if (wq.size() != 0) void'(wq.pop_front());
          bitidx = NBITS - 1;
        end else begin
          bitidx--;
        end
      end else begin
        comp_out = 1'($urandom);
      end
    end
  end

  task automatic clr_counts();
    n_busy = 0; n_init = 0; n_samp = 0; n_cmp = 0; n_logic = 0; n_multi = 0; n_init_rise = 0;
  endtask

  task automatic run_conv(input logic [15:0] mask, input bit cont, input int n, input int ti,
                          input int ts, input bit rdy_low, input bit restart,
                          input bit use_fw, input logic [NBITS-1:0] fw);
    logic [3:0]       cur;
    logic [NBITS-1:0] w;
    int               len, guard;
    t_init     = CNT_W'(ti);
    t_samp     = CNT_W'(ts);
    chan_mask  = mask;
    continuous = cont;
    cur = first_at(mask, msel);
    for (int k = 0; k < n; k++) begin
      w = (use_fw && k == 0) ? fw : NBITS'($urandom);
      wq.push_back(w);
      if (!rdy_low || k == 0) sb.push_back('{data: w, chan: cur});
      cur = next_after(mask, cur);
    end
    msel = cur;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (cont) begin
      guard = 0;
      while (n_init_rise < n && guard < 5000) begin tick(); guard++; end
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    if (restart) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    guard = 0;
    while (busy && guard < 5000) begin tick(); guard++; end
    chk("idle_timeout", 32'(busy), 0);
    len = (ti + 1) + (ts + 1) + 2 * NBITS + 1;
    chk("busy_cycles",  n_busy,  n * len);
    chk("init_cycles",  n_init,  n * (ti + 1));
    chk("samp_cycles",  n_samp,  n * (ts + 1));
    chk("cmp_cycles",   n_cmp,   n * NBITS);
    chk("logic_cycles", n_logic, n * NBITS);
    chk("multi_strobe", n_multi, 0);
    chk("adc_sel_next", 32'(adc_sel), 32'(msel));
    repeat (2) tick();
    if (!rdy_low) chk("sb_drained", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {28'd0, seq_init, seq_samp, seq_cmp, seq_logic}, 0);
    chk({tag, "_adc_sel"}, 32'(adc_sel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_data"}, 32'(res_data), 0);
    chk({tag, "_res_chan"}, 32'(res_chan), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0; comp_out = 1'b0;
    res_ready = 1'b1; clr_overrun = 1'b0; chan_mask = 16'h0; t_init = '0; t_samp = '0;
    clr_counts();
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single conversion with known bit pattern: ADC 4, result 0xB2, 24 cycles.
    run_conv(16'h0010, 1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 8'hB2);

    // Park on ADC 15, then wrap 15 -> 0 -> 1 in continuous mode.
    run_conv(16'h8000, 1'b0, 1, 1, 1, 1'b0, 1'b0, 1'b0, '0);
    run_conv(16'h8003, 1'b1, 3, 1, 2, 1'b0, 1'b0, 1'b0, '0);

    // Start with empty mask does nothing.
    chan_mask = 16'h0;
    clr_counts();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("mask0_busy", 32'(busy), 0);
    chk("mask0_init", n_init, 0);
    chk("mask0_adc_sel", 32'(adc_sel), 32'(msel));

    // One-cycle phases, and a start while busy that must be ignored.
    run_conv(16'h0400, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    run_conv(16'h0240, 1'b0, 1, 3, 4, 1'b0, 1'b1, 1'b0, '0);

    // Backpressure: first result held, second dropped, overrun raised then cleared.
    res_ready = 1'b0;
    run_conv(16'h0009, 1'b1, 2, 1, 2, 1'b1, 1'b0, 1'b0, '0);
    chk("bp_valid_held", 32'(res_valid), 1);
    chk("bp_overrun", 32'(overrun), 1);
    res_ready = 1'b1;
    repeat (2) tick();
    chk("bp_drained", sb.size(), 0);
    chk("bp_valid_clear", 32'(res_valid), 0);
    chk("bp_overrun_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("bp_overrun_clr", 32'(overrun), 0);

    // Randomized conversions.
    for (int it = 0; it < 12; it++) begin
      logic [15:0] m;
      bit          c;
      m = 16'($urandom);
      if (m == 16'h0) m = 16'h0001;
      c = 1'($urandom);
      run_conv(m, c, c ? 1 + int'($urandom % 3) : 1, int'($urandom % 5), int'($urandom % 5),
               1'b0, 1'b0, 1'b0, '0);
    end

    // Reset during SAMP abandons the conversion.
    t_init = 8'd2; t_samp = 8'd6; chan_mask = 16'h0100; continuous = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!seq_samp && guard < 100) begin tick(); guard++; end
    chk("samp_reached", 32'(seq_samp), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midsamp");
    wq.delete();
    sb.delete();
    bitidx = NBITS - 1;
    msel = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("no_result_after_reset", 32'(res_valid), 0);
    run_conv(16'h0100, 1'b0, 1, 2, 6, 1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
